// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures one decoded instruction per cycle, forwards
// EX/MEM and MEM/WB results into the ALU operands and detects load-use hazards.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter logic [3:0]  NOP_OP = 4'b0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_sel_a,
    input  logic            id_sel_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_out,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_valid,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            use_rs1;
        logic            use_rs2;
        logic [3:0]      op;
        logic            sel_a;
        logic            sel_b;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_t;

    ex_t             ex_q, ex_d, bubble_c, load_c;
    logic            lu_c;
    logic [XLEN-1:0] fwd_rs1_c, fwd_rs2_c;

    // Load in EX whose destination is read by the instruction in ID.
    assign lu_c = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                  ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                   (id_use_rs2 & (id_rs2 == ex_q.rd)));

    assign stall_out = (lu_c | hold) & ~flush;

    always_comb begin
        bubble_c    = '0;
        bubble_c.op = NOP_OP;

        load_c           = '0;
        load_c.valid     = id_valid;
        load_c.pc        = id_pc;
        load_c.rs1_val   = id_rs1_val;
        load_c.rs2_val   = id_rs2_val;
        load_c.imm       = id_imm;
        load_c.rs1       = id_rs1;
        load_c.rs2       = id_rs2;
        load_c.rd        = id_rd;
        load_c.use_rs1   = id_use_rs1;
        load_c.use_rs2   = id_use_rs2;
        load_c.op        = id_alu_op;
        load_c.sel_a     = id_sel_a;
        load_c.sel_b     = id_sel_b;
        load_c.reg_write = id_reg_write & id_valid;
        load_c.mem_read  = id_mem_read  & id_valid;
        load_c.mem_write = id_mem_write & id_valid;

        ex_d = ex_q;
        if (flush) begin
            ex_d = bubble_c;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (lu_c) begin
            ex_d = bubble_c;
        end else begin
            ex_d = load_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= bubble_c;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM wins over MEM/WB; x0 and unused source registers never forward.
    always_comb begin
        fwd_rs1_c = ex_q.rs1_val;
        if (ex_q.use_rs1 && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs1)) begin
            fwd_rs1_c = exmem_result;
        end else if (ex_q.use_rs1 && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs1)) begin
            fwd_rs1_c = memwb_result;
        end

        fwd_rs2_c = ex_q.rs2_val;
        if (ex_q.use_rs2 && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs2)) begin
            fwd_rs2_c = exmem_result;
        end else if (ex_q.use_rs2 && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs2)) begin
            fwd_rs2_c = memwb_result;
        end
    end

    assign alu_a         = ex_q.sel_a ? ex_q.pc  : fwd_rs1_c;
    assign alu_b         = ex_q.sel_b ? ex_q.imm : fwd_rs2_c;
    assign ex_store_data = fwd_rs2_c;
    assign alu_op        = ex_q.op;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX outputs are queued when stimulus
// is applied and popped for comparison once the outputs have settled.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [3:0]  id_alu_op;
    logic        id_sel_a, id_sel_b, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        flush, hold;
    logic        stall_out;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] a, b, st;
        logic [3:0]  op;
        logic        v;
        logic [4:0]  rd;
        logic        rw, mr, mw, stall;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_sel_a(id_sel_a), .id_sel_b(id_sel_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .flush(flush), .hold(hold), .stall_out(stall_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] st, input logic [3:0] op, input logic v,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic mw, input logic stall);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.st = st; e.op = op; e.v = v;
        e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.stall = stall;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, field, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        tests_run++;
        assert (sb.size() > 0) else begin
            tests_failed++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "alu_a", alu_a, e.a);
            cmp(e.tag, "alu_b", alu_b, e.b);
            cmp(e.tag, "store", ex_store_data, e.st);
            cmp(e.tag, "alu_op", 32'(alu_op), 32'(e.op));
            cmp(e.tag, "ex_valid", 32'(ex_valid), 32'(e.v));
            cmp(e.tag, "ex_rd", 32'(ex_rd), 32'(e.rd));
            cmp(e.tag, "reg_write", 32'(ex_reg_write), 32'(e.rw));
            cmp(e.tag, "mem_read", 32'(ex_mem_read), 32'(e.mr));
            cmp(e.tag, "mem_write", 32'(ex_mem_write), 32'(e.mw));
            cmp(e.tag, "stall_out", 32'(stall_out), 32'(e.stall));
        end
    endtask

    task automatic id_clear();
        id_valid = 0; id_pc = '0; id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_alu_op = '0; id_sel_a = 0; id_sel_b = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic fwd_clear();
        exmem_rd = '0; exmem_reg_write = 0; exmem_result = '0;
        memwb_rd = '0; memwb_reg_write = 0; memwb_result = '0;
    endtask

    initial begin
        reset = 1; flush = 0; hold = 0;
        id_clear();
        fwd_clear();
        tick(); tick();
        reset = 0;
        tick();
        expect_out("reset", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        check_out();

        // ADD x8, x5, x6
        id_valid = 1; id_rs1 = 5; id_rs1_val = 10; id_rs2 = 6; id_rs2_val = 3;
        id_use_rs1 = 1; id_use_rs2 = 1; id_alu_op = 4'b0010; id_rd = 8; id_reg_write = 1;
        tick();
        id_clear();
        expect_out("add", 10, 3, 3, 4'b0010, 1, 8, 1, 0, 0, 0);
        check_out();

        exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h55;
        memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h99;
        expect_out("fwd_exmem", 32'h55, 3, 3, 4'b0010, 1, 8, 1, 0, 0, 0);
        check_out();
        exmem_reg_write = 0;
        expect_out("fwd_memwb", 32'h99, 3, 3, 4'b0010, 1, 8, 1, 0, 0, 0);
        check_out();
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        expect_out("fwd_x0", 10, 3, 3, 4'b0010, 1, 8, 1, 0, 0, 0);
        check_out();
        exmem_reg_write = 0; memwb_rd = 6;
        expect_out("fwd_rs2", 10, 32'h99, 32'h99, 4'b0010, 1, 8, 1, 0, 0, 0);
        check_out();
        fwd_clear();

        // LW x7, 4(x1)
        id_valid = 1; id_rs1 = 1; id_rs1_val = 32'h40; id_use_rs1 = 1;
        id_imm = 4; id_sel_b = 1; id_alu_op = 4'b0001; id_rd = 7;
        id_mem_read = 1; id_reg_write = 1;
        tick();
        id_clear();
        id_valid = 1; id_rs1 = 3; id_rs1_val = 5; id_rs2 = 7; id_rs2_val = 0;
        id_use_rs1 = 1; id_use_rs2 = 1; id_alu_op = 4'b0010; id_rd = 9; id_reg_write = 1;
        expect_out("lu_stall", 32'h40, 4, 0, 4'b0001, 1, 7, 1, 1, 0, 1);
        check_out();
        tick();
        expect_out("lu_bubble", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        check_out();
        tick();
        id_clear();
        memwb_rd = 7; memwb_reg_write = 1; memwb_result = 32'h77;
        expect_out("lu_dep", 5, 32'h77, 32'h77, 4'b0010, 1, 9, 1, 0, 0, 0);
        check_out();

        hold = 1;
        for (int i = 0; i < 3; i++) begin
            id_valid = 1; id_rs1 = 5'(i + 2); id_rs1_val = 32'hAAA0 + 32'(i);
            id_alu_op = 4'(i + 5); id_rd = 5'(i + 3); id_mem_write = 1;
            tick();
            expect_out("hold", 5, 32'h77, 32'h77, 4'b0010, 1, 9, 1, 0, 0, 1);
            check_out();
        end
        flush = 1;
        expect_out("flush_hold_pre", 5, 32'h77, 32'h77, 4'b0010, 1, 9, 1, 0, 0, 0);
        check_out();
        tick();
        expect_out("flush_hold", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        check_out();
        flush = 0; hold = 0;
        id_clear();
        fwd_clear();

        // SW with PC/imm operands and forwarded store data
        id_valid = 1; id_sel_a = 1; id_sel_b = 1; id_pc = 32'h100; id_imm = 32'hFFFF_FFFC;
        id_rs2 = 4; id_rs2_val = 32'h11; id_use_rs2 = 1; id_alu_op = 4'b0011; id_mem_write = 1;
        tick();
        id_clear();
        exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'h1234;
        expect_out("sel_pc_imm", 32'h100, 32'hFFFF_FFFC, 32'h1234, 4'b0011, 1, 0, 0, 0, 1, 0);
        check_out();
        fwd_clear();

        // Invalid slot: fields captured, control bits masked
        id_valid = 0; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
        id_rd = 5; id_alu_op = 4'b0110; id_rs1_val = 32'h22;
        tick();
        id_clear();
        expect_out("invalid_mask", 32'h22, 0, 0, 4'b0110, 0, 5, 0, 0, 0, 0);
        check_out();

        reset = 1;
        tick();
        reset = 0;
        expect_out("reset2", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        check_out();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
